// File: rtl/exc_pkg.sv
// Shared types and constants for the exception unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package exc_pkg;
    localparam int PC_W    = 32;
    localparam int CAUSE_W = 5;

    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL  = 5'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_MISALIGN = 5'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL    = 5'd11;
    localparam logic [CAUSE_W-1:0] CAUSE_OVERFLOW = 5'd12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_REDIRECT,
        S_HANDLER,
        S_RETURN
    } exc_state_t;
endpackage

// File: rtl/exc_priority_sel.sv
// Picks the oldest (highest-index) requesting stage and muxes its pc/cause.
// Latency: combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module exc_priority_sel
    import exc_pkg::*;
#(
    parameter int NSRC = 4
) (
    input  logic [NSRC-1:0]         src_valid,
    input  logic [NSRC*PC_W-1:0]    src_pc,
    input  logic [NSRC*CAUSE_W-1:0] src_cause,
    output logic [NSRC-1:0]         grant,
    output logic [PC_W-1:0]         sel_pc,
    output logic [CAUSE_W-1:0]      sel_cause
);

    // Ascending scan: a later (older) stage overrides any younger one.
    always_comb begin
        grant     = '0;
        sel_pc    = '0;
        sel_cause = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_valid[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                sel_pc    = src_pc[PC_W*i +: PC_W];
                sel_cause = src_cause[CAUSE_W*i +: CAUSE_W];
            end
        end
    end

endmodule

// File: rtl/exception_unit.sv
// Trap sequencer: oldest request -> exception pulse, flush, vector redirect, handler, return.
// Latency: request to exception_sig 1 cycle; to trap-vector redirect FLUSH_CYCLES+1 cycles.
// Backpressure: none; requests outside IDLE are dropped (counted when EXC_COUNT_EN is defined).
module exception_unit
    import exc_pkg::*;
#(
    parameter int          NSRC         = 4,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NSRC-1:0]         src_valid,
    input  logic [NSRC*PC_W-1:0]    src_pc,
    input  logic [NSRC*CAUSE_W-1:0] src_cause,
    input  logic                    trap_return,
    input  logic [PC_W-1:0]         epc_in,
    output logic                    exception_sig,
    output logic [PC_W-1:0]         exception_pc,
    output logic [CAUSE_W-1:0]      exception_cause,
    output logic                    flush,
    output logic                    pc_redirect_valid,
    output logic [PC_W-1:0]         pc_redirect,
    output logic                    in_trap
`ifdef EXC_COUNT_EN
    ,
    output logic [31:0]             exc_taken_cnt,
    output logic [31:0]             exc_dropped_cnt
`endif
);

    localparam logic [3:0] FLUSH_CNT_INIT = 4'(FLUSH_CYCLES - 1);

    exc_state_t          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [NSRC-1:0]     grant;
    logic [PC_W-1:0]     sel_pc;
    logic [CAUSE_W-1:0]  sel_cause;
    logic                any_req;

    logic                sig_d, flush_d, rv_d, trap_d;
    logic [PC_W-1:0]     redir_d, epc_d;
    logic [CAUSE_W-1:0]  cause_d;

    exc_priority_sel #(.NSRC(NSRC)) u_sel (
        .src_valid (src_valid),
        .src_pc    (src_pc),
        .src_cause (src_cause),
        .grant     (grant),
        .sel_pc    (sel_pc),
        .sel_cause (sel_cause)
    );

    assign any_req = |grant;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sig_d   = 1'b0;
        flush_d = 1'b0;
        rv_d    = 1'b0;
        trap_d  = 1'b0;
        redir_d = pc_redirect;
        epc_d   = exception_pc;
        cause_d = exception_cause;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_FLUSH;
                    sig_d   = 1'b1;
                    flush_d = 1'b1;
                    cnt_d   = FLUSH_CNT_INIT;
                    epc_d   = sel_pc;
                    cause_d = sel_cause;
                end
            end
            S_FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_REDIRECT;
                    rv_d    = 1'b1;
                    redir_d = TRAP_VECTOR;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    flush_d = 1'b1;
                end
            end
            S_REDIRECT: begin
                state_d = S_HANDLER;
                trap_d  = 1'b1;
            end
            S_HANDLER: begin
                // Return beats any coincident request; nested traps are unsupported.
                if (trap_return) begin
                    state_d = S_RETURN;
                    rv_d    = 1'b1;
                    redir_d = epc_in;
                    flush_d = 1'b1;
                end else begin
                    trap_d  = 1'b1;
                end
            end
            S_RETURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_IDLE;
            cnt_q             <= '0;
            exception_sig     <= 1'b0;
            exception_pc      <= '0;
            exception_cause   <= '0;
            flush             <= 1'b0;
            pc_redirect_valid <= 1'b0;
            pc_redirect       <= '0;
            in_trap           <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            exception_sig     <= sig_d;
            exception_pc      <= epc_d;
            exception_cause   <= cause_d;
            flush             <= flush_d;
            pc_redirect_valid <= rv_d;
            pc_redirect       <= redir_d;
            in_trap           <= trap_d;
        end
    end

`ifdef EXC_COUNT_EN
    logic req_dropped;
    assign req_dropped = any_req && (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_taken_cnt   <= '0;
            exc_dropped_cnt <= '0;
        end else begin
            if (sig_d)
                exc_taken_cnt <= exc_taken_cnt + 32'd1;
            if (req_dropped)
                exc_dropped_cnt <= exc_dropped_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exception_unit.sv
// Bench for exception_unit: directed scenarios then random traffic, checked against a
// timeline model (event queue for exception/redirect strobes, per-cycle expected levels).
module tb_exception_unit;
    localparam int NSRC = 4;
    localparam int F    = 2;
    localparam logic [31:0] TV = 32'h0000_0100;
    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  src_valid = '0;
    logic [127:0] src_pc = '0;
    logic [19:0] src_cause = '0;
    logic        trap_return = 1'b0;
    logic [31:0] epc_in = '0;
    logic        exception_sig, flush, pc_redirect_valid, in_trap;
    logic [31:0] exception_pc, pc_redirect;
    logic [4:0]  exception_cause;
`ifdef EXC_COUNT_EN
    logic [31:0] exc_taken_cnt, exc_dropped_cnt;
`endif

    exception_unit #(.NSRC(NSRC), .FLUSH_CYCLES(F), .TRAP_VECTOR(TV)) dut (
        .clk(clk), .rst(rst), .src_valid(src_valid), .src_pc(src_pc), .src_cause(src_cause),
        .trap_return(trap_return), .epc_in(epc_in), .exception_sig(exception_sig),
        .exception_pc(exception_pc), .exception_cause(exception_cause), .flush(flush),
        .pc_redirect_valid(pc_redirect_valid), .pc_redirect(pc_redirect), .in_trap(in_trap)
`ifdef EXC_COUNT_EN
        , .exc_taken_cnt(exc_taken_cnt), .exc_dropped_cnt(exc_dropped_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_exc;
        int          cyc;
        logic [31:0] val;
        logic [4:0]  cause;
    } ev_t;
    ev_t ev_q[$];

    bit          exp_ok[MAXC];
    bit          exp_rst[MAXC];
    bit          exp_flush[MAXC];
    bit          exp_trap[MAXC];
    logic [31:0] exp_pc[MAXC];
    logic [4:0]  exp_cause[MAXC];
    int          exp_taken[MAXC];
    int          exp_drop[MAXC];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state: a trap occupies cycles t_sig .. ret_at inclusive.
    bit          busy = 0;
    int          t_sig, hstart, ret_at;
    logic [31:0] last_pc = '0;
    logic [4:0]  last_cause = '0;
    int          taken = 0, dropped = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        int c, n, w;
        c = cyc;
        n = c + 1;
        if (rst) begin
            busy = 0; last_pc = '0; last_cause = '0; taken = 0; dropped = 0;
            while (ev_q.size() > 0 && ev_q[$].cyc > c) void'(ev_q.pop_back());
        end else if (!busy) begin
            if (src_valid != 4'b0) begin
                w = 0;
                for (int i = NSRC - 1; i >= 0; i--)
                    if (src_valid[i] && w == 0) w = i + 1;
                w = w - 1;
                last_pc    = src_pc[32*w +: 32];
                last_cause = src_cause[5*w +: 5];
                ev_q.push_back('{1'b1, n, last_pc, last_cause});
                ev_q.push_back('{1'b0, n + F, TV, 5'd0});
                busy = 1; t_sig = n; hstart = n + F + 1; ret_at = -1;
                taken++;
            end
        end else begin
            if (src_valid != 4'b0) dropped++;
            if (ret_at < 0 && c >= hstart && trap_return) begin
                ret_at = n;
                ev_q.push_back('{1'b0, n, epc_in, 5'd0});
            end else if (ret_at >= 0 && c == ret_at) begin
                busy = 0;
            end
        end
        if (n < MAXC) begin
            exp_ok[n]    = 1;
            exp_rst[n]   = rst;
            exp_flush[n] = busy && (n < t_sig + F || n == ret_at);
            exp_trap[n]  = busy && n >= hstart && ret_at < 0;
            exp_pc[n]    = last_pc;
            exp_cause[n] = last_cause;
            exp_taken[n] = taken;
            exp_drop[n]  = dropped;
        end
        cyc = n;
    end

    always @(negedge clk) begin
        int k;
        ev_t e;
        k = cyc;
        if (k < MAXC && exp_ok[k]) begin
            while (ev_q.size() > 0 && ev_q[0].cyc < k) begin
                e = ev_q.pop_front();
                chk(e.is_exc ? "missed_exception" : "missed_redirect", 32'd0, 32'd1);
            end
            chk("flush", {31'd0, flush}, {31'd0, exp_flush[k]});
            chk("in_trap", {31'd0, in_trap}, {31'd0, exp_trap[k]});
            chk("exception_pc", exception_pc, exp_pc[k]);
            chk("exception_cause", {27'd0, exception_cause}, {27'd0, exp_cause[k]});
`ifdef EXC_COUNT_EN
            chk("exc_taken_cnt", exc_taken_cnt, exp_taken[k]);
            chk("exc_dropped_cnt", exc_dropped_cnt, exp_drop[k]);
`endif
            if (exp_rst[k]) begin
                chk("rst_exception_sig", {31'd0, exception_sig}, 32'd0);
                chk("rst_redirect_valid", {31'd0, pc_redirect_valid}, 32'd0);
                chk("rst_pc_redirect", pc_redirect, 32'd0);
            end
            if (exception_sig || pc_redirect_valid) begin
                if (ev_q.size() == 0 || ev_q[0].cyc != k) begin
                    chk("unexpected_strobe", {30'd0, exception_sig, pc_redirect_valid}, 32'd0);
                end else begin
                    e = ev_q.pop_front();
                    chk("strobe_kind", {30'd0, exception_sig, pc_redirect_valid},
                        e.is_exc ? 32'd2 : 32'd1);
                    if (e.is_exc) begin
                        chk("sig_pc", exception_pc, e.val);
                        chk("sig_cause", {27'd0, exception_cause}, {27'd0, e.cause});
                    end else begin
                        chk("redirect_target", pc_redirect, e.val);
                    end
                end
            end
        end
    end

    task automatic drive(input logic [3:0] v, input logic tr, input logic r);
        src_valid   = v;
        trap_return = tr;
        rst         = r;
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [31:0] pc, input logic [4:0] cause);
        src_pc[32*i +: 32]  = pc;
        src_cause[5*i +: 5] = cause;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'b0, 1'b0, 1'b0);
    endtask

    initial begin
        drive(4'b0, 1'b0, 1'b1);
        drive(4'b0, 1'b0, 1'b1);

        // Single IF exception with drops in FLUSH and HANDLER, then return to 0x44.
        set_slot(0, 32'h40, 5'd2);
        drive(4'b0001, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b0);
        drive(4'b0100, 1'b0, 1'b0);
        idle(3);
        drive(4'b1000, 1'b0, 1'b0);
        idle(1);
        epc_in = 32'h44;
        drive(4'b0000, 1'b1, 1'b0);
        idle(3);

        // Oldest of several simultaneous requests wins.
        set_slot(3, 32'h80, 5'd4);
        set_slot(1, 32'h84, 5'd11);
        set_slot(0, 32'h88, 5'd12);
        drive(4'b1011, 1'b0, 1'b0);
        idle(5);
        epc_in = 32'h200;
        drive(4'b0001, 1'b1, 1'b0);
        idle(3);

        // Reset during the second flush cycle, then a clean exception.
        set_slot(0, 32'h40, 5'd2);
        drive(4'b0001, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b1);
        idle(2);
        drive(4'b0001, 1'b0, 1'b0);
        idle(5);
        epc_in = 32'h300;
        drive(4'b0000, 1'b1, 1'b0);
        idle(3);

        for (int i = 0; i < 2000; i++) begin
            for (int s = 0; s < NSRC; s++)
                set_slot(s, $urandom & 32'hffff_fffc, 5'($urandom_range(0, 31)));
            epc_in = $urandom & 32'hffff_fffc;
            drive(($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0,
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 199) == 0));
        end

        for (int i = 0; i < 10; i++) drive(4'b0, 1'b1, 1'b0);
        idle(4);
        chk("queue_drained", ev_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/exception_unit.md
Name: exception_unit

Overview:
- Upstream feeder of the CSR block.
- Collects exception requests from the pipeline stages and picks the oldest one.
- Emits a single-cycle exception_sig with exception_pc/exception_cause, which the CSR block captures.
- Sequences the pipeline flush, the trap-vector redirect and the trap return.

Parameters:
- NSRC, 4: number of exception sources (index 0 = IF, youngest; NSRC-1 = MEM, oldest).
- FLUSH_CYCLES, 2: cycles flush is held on entry (legal range 1..15).
- TRAP_VECTOR, 32'h0000_0100: handler entry PC.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- src_valid  in  NSRC  per-stage exception request
- src_pc  in  NSRC*32  per-stage faulting PC; slot i = bits [32*i+31:32*i]
- src_cause  in  NSRC*5  per-stage cause code; slot i = bits [5*i+4:5*i]
- trap_return  in  1  return-from-trap instruction committed
- epc_in  in  32  saved EPC read back from CSR
- exception_sig  out  1  one-cycle pulse to CSR
- exception_pc  out  32  winning PC (to CSR)
- exception_cause  out  5  winning cause (to CSR)
- flush  out  1  kill all in-flight instructions
- pc_redirect_valid  out  1  one-cycle fetch redirect strobe
- pc_redirect  out  32  redirect target
- in_trap  out  1  handler running; new exceptions masked

Behaviour:
- All outputs are registered. Reset value of every output is 0. Reset state is IDLE.
- rst asserted in any state forces IDLE and zeroes all outputs on the next edge, aborting any flush or redirect in progress.
- States: IDLE, FLUSH, REDIRECT, HANDLER, RETURN.
- Priority: the highest set index of src_valid wins (the oldest stage).
- IDLE:
  - At an edge with any src_valid set, latch the winner's pc and cause.
  - Next cycle: exception_sig=1, flush=1, load flush counter with FLUSH_CYCLES-1, go to FLUSH.
  - If no src_valid is set, stay in IDLE. trap_return is ignored in IDLE.
- FLUSH:
  - exception_sig drops after exactly 1 cycle.
  - flush stays high for exactly FLUSH_CYCLES cycles in total, counting the exception_sig cycle.
  - When the counter reaches 0, go to REDIRECT.
  - src_valid and trap_return are ignored.
- REDIRECT:
  - pc_redirect_valid=1, pc_redirect=TRAP_VECTOR, flush=0 for one cycle.
  - Then go to HANDLER.
- HANDLER:
  - in_trap=1.
  - Any src_valid is dropped (nested traps are not supported).
  - When trap_return=1 is sampled at an edge, go to RETURN.
  - If trap_return and src_valid arrive in the same cycle, the return wins and the exception is dropped.
- RETURN (one cycle):
  - pc_redirect_valid=1, pc_redirect=epc_in (sampled on the trap_return edge), flush=1, in_trap=0.
  - Then go to IDLE.
  - src_valid in this cycle is ignored. A request still asserted in the following IDLE cycle is taken.
- exception_pc and exception_cause hold their values until the next exception. They are valid at least while exception_sig=1.
- Latency: src_valid edge to exception_sig = 1 cycle. Exception to trap-vector redirect = FLUSH_CYCLES+1 cycles.

Optional Feature:
- Macro: EXC_COUNT_EN.
- When defined, two extra outputs are added:
  - exc_taken_cnt [31:0]: increments on each exception_sig.
  - exc_dropped_cnt [31:0]: increments on each cycle where a src_valid is ignored in FLUSH, REDIRECT, HANDLER or RETURN.
- Both counters reset to 0 and wrap modulo 2^32.
- When the macro is not defined, the ports and logic are absent and the remaining behaviour is identical.

Decomposition:
- Shared package exc_pkg holds:
  - the state enum;
  - cause constants: CAUSE_ILLEGAL=5'd2, CAUSE_ECALL=5'd11, CAUSE_MISALIGN=5'd4, CAUSE_OVERFLOW=5'd12;
  - the width localparams PC_W=32 and CAUSE_W=5.
- Sub-module exc_priority_sel is combinational: highest-index valid to one-hot grant plus muxed pc/cause.
- The FSM, flush counter and output registers stay in the top module.

Test Plan:
- Single IF exception (src_valid=4'b0001, pc=0x40, cause=2):
  - exception_sig pulses 1 cycle later with pc 0x40 and cause 2;
  - flush high for 2 cycles;
  - pc_redirect=0x100 in cycle 3;
  - in_trap=1 afterwards.
- Simultaneous requests (src_valid=4'b1011, MEM pc=0x80 cause=4, IF pc=0x88): exception_pc=0x80, exception_cause=4.
- Masking: src_valid pulsed during FLUSH and HANDLER:
  - no second exception_sig;
  - with EXC_COUNT_EN, exc_dropped_cnt=2 and exc_taken_cnt=1.
- Return with epc_in=0x44 and trap_return=1 in HANDLER:
  - next cycle pc_redirect_valid=1, pc_redirect=0x44, flush=1, in_trap=0;
  - IDLE after that.
- trap_return and src_valid together in HANDLER: RETURN taken, exception dropped, IDLE reached.
- rst asserted in the second FLUSH cycle: all outputs 0 the next cycle, and a new exception afterwards behaves as in the first scenario.
